// File: rtl/flick_conditioner.sv
// -----------------------------------------------------------------------------
// flick_conditioner
//
// Front end of the bound-flasher LED sequencer. Turns the raw, asynchronous,
// bouncing flick push-button into clean control in the clk domain. It also
// paces the sequencer with a free-running step clock-enable.
//
// Ports
//   clk          in   system clock, all state changes on the rising edge
//   rst_n        in   asynchronous, active-low reset
//   flick_raw    in   raw button, asynchronous to clk, may bounce
//   flick_level  out  debounced button level (registered)
//   flick_pulse  out  one-cycle strobe per accepted press (registered)
//   flick_req    out  sticky press request, held until consumed by one
//                     step_tick (registered)
//   step_tick    out  one-cycle clock-enable, every TICK_DIV cycles (registered)
//
// Parameters
//   DB_CYCLES    consecutive stable synchronised samples needed to accept a
//                press or a release (>= 2)
//   TICK_DIV     clk cycles per step_tick period (>= 2)
//
// Latency: a clean edge on flick_raw shows up on flick_level after
// DB_CYCLES+3 rising edges. The synchroniser accounts for 2 edges, leaving the
// wait state accounts for 1, and DB_CYCLES counted samples account for the rest.
// -----------------------------------------------------------------------------
module flick_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int TICK_DIV  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flick_raw,
  output logic flick_level,
  output logic flick_pulse,
  output logic flick_req,
  output logic step_tick
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TCK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [TCK_W-1:0] TCK_MAX = TCK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TCK_W-1:0] tick_cnt;
  logic             press_accept;

  // ---- stage 0/1: two-flop synchroniser; only s2 is used downstream ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= flick_raw;
      s2 <= s1;
    end
  end

  // This edge accepts a press. flick_req reads it so that it can be set on
  // the same edge that raises flick_pulse.
  assign press_accept = (state == PRESS_WAIT) && s2 && (cnt == CNT_MAX);

  // ---- stage 2: debounce FSM with registered outputs ----
  // The counter restarts at 0 on every state change. Because it stops at
  // CNT_MAX (which triggers the exit), it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      flick_level <= 1'b0;
      flick_pulse <= 1'b0;
      flick_req   <= 1'b0;
    end else begin
      flick_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!s2) begin
            // Bounce: the input fell before it had been stable long enough.
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state       <= PRESSED;
            cnt         <= '0;
            flick_level <= 1'b1;
            flick_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        PRESSED: begin
          if (!s2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (s2) begin
            // Release glitch: go back to PRESSED quietly, with no new pulse.
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state       <= IDLE;
            cnt         <= '0;
            flick_level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state       <= IDLE;
          cnt         <= '0;
          flick_level <= 1'b0;
        end
      endcase

      // Sticky request. A new press wins over consumption by a step, so a
      // press that lands on a consuming tick is not lost. A press that
      // arrives while a request is pending merges into that request.
      if (press_accept) begin
        flick_req <= 1'b1;
      end else if (step_tick && flick_req) begin
        flick_req <= 1'b0;
      end
    end
  end

  // ---- tick divider: free-running, step_tick follows each wrap edge ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      step_tick <= 1'b0;
    end else begin
      if (tick_cnt == TCK_MAX) begin
        tick_cnt  <= '0;
        step_tick <= 1'b1;
      end else begin
        tick_cnt  <= tick_cnt + TCK_W'(1);
        step_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flick_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for flick_conditioner.
// dut1 uses DB_CYCLES=4 and TICK_DIV=8. dut2 uses DB_CYCLES=4 and TICK_DIV=16.
// The longer tick period of dut2 allows a second press to coincide with the
// consuming tick while a request is still pending.
// Edge numbers count rising edges since the most recent reset release. Each
// table row drives its raw value on every edge after the previous row, up to
// and including its own edge. The expected outputs are then sampled 1 ns
// after that edge.
// -----------------------------------------------------------------------------
module tb_flick_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic raw1, raw2;
  logic lvl1, pls1, req1, tck1;
  logic lvl2, pls2, req2, tck2;

  int n = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flick_conditioner #(.DB_CYCLES(4), .TICK_DIV(8)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flick_raw  (raw1),
    .flick_level(lvl1),
    .flick_pulse(pls1),
    .flick_req  (req1),
    .step_tick  (tck1)
  );

  flick_conditioner #(.DB_CYCLES(4), .TICK_DIV(16)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flick_raw  (raw2),
    .flick_level(lvl2),
    .flick_pulse(pls2),
    .flick_req  (req2),
    .step_tick  (tck2)
  );

  typedef struct {
    int   at;
    bit   sel;   // 0 = dut1, 1 = dut2
    logic raw;
    logic lvl;
    logic pls;
    logic req;
    logic tck;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int at, bit sel, logic raw,
                              logic l, logic p, logic r, logic t);
    vec_t v;
    v.at = at; v.sel = sel; v.raw = raw;
    v.lvl = l; v.pls = p; v.req = r; v.tck = t;
    return v;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%b required=%b", name, n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    #1;
  endtask

  logic bnc [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    // -------- table fill --------
    // Clean press on dut1: raw high from edge 25, so the accept lands on edge 31.
    tbl.push_back(mk(30, 0, 1'b1, 0, 0, 0, 0));
    tbl.push_back(mk(31, 0, 1'b1, 1, 1, 1, 0));
    tbl.push_back(mk(32, 0, 1'b1, 1, 0, 1, 1));
    tbl.push_back(mk(33, 0, 1'b1, 1, 0, 0, 0));
    tbl.push_back(mk(36, 0, 1'b1, 1, 0, 0, 0));
    // Release glitch on dut1: raw low on edges 37-38.
    tbl.push_back(mk(38, 0, 1'b0, 1, 0, 0, 0));
    tbl.push_back(mk(40, 0, 1'b1, 1, 0, 0, 1));
    tbl.push_back(mk(41, 0, 1'b1, 1, 0, 0, 0));
    tbl.push_back(mk(42, 0, 1'b1, 1, 0, 0, 0));
    tbl.push_back(mk(44, 0, 1'b1, 1, 0, 0, 0));
    // Real release on dut1: raw low from edge 45, so level drops after edge 51.
    tbl.push_back(mk(50, 0, 1'b0, 1, 0, 0, 0));
    tbl.push_back(mk(51, 0, 1'b0, 0, 0, 0, 0));
    tbl.push_back(mk(54, 0, 1'b0, 0, 0, 0, 0));
    // Bounce on dut1: edges 55-62 carry 1,1,0,0,1,1,0,0, then raw stays low.
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(55 + i, 0, (i < 8) ? bnc[i] : 1'b0, 0, 0, 0,
                       ((55 + i) % 8 == 0) ? 1'b1 : 1'b0));
    // Collision on dut2: first accept at edge 85; second accept at edge 97,
    // on the consuming tick (tick is high after edge 96).
    tbl.push_back(mk(78,  1, 1'b0, 0, 0, 0, 0));
    tbl.push_back(mk(83,  1, 1'b1, 0, 0, 0, 0));
    tbl.push_back(mk(85,  1, 1'b0, 1, 1, 1, 0));
    tbl.push_back(mk(86,  1, 1'b0, 1, 0, 1, 0));
    tbl.push_back(mk(90,  1, 1'b0, 0, 0, 1, 0));
    tbl.push_back(mk(95,  1, 1'b1, 0, 0, 1, 0));
    tbl.push_back(mk(96,  1, 1'b1, 0, 0, 1, 1));
    tbl.push_back(mk(97,  1, 1'b1, 1, 1, 1, 0));
    tbl.push_back(mk(98,  1, 1'b1, 1, 0, 1, 0));
    tbl.push_back(mk(112, 1, 1'b1, 1, 0, 1, 1));
    tbl.push_back(mk(113, 1, 1'b1, 1, 0, 0, 0));

    // -------- reset and tick period --------
    rst_n = 1'b0;
    raw1  = 1'b0;
    raw2  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_level", lvl1, 1'b0);
      chk("rst_pulse", pls1, 1'b0);
      chk("rst_req",   req1, 1'b0);
      chk("rst_tick",  tck1, 1'b0);
    end
    #4 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      chk("tick8_period",  tck1, (n % 8 == 0)  ? 1'b1 : 1'b0);
      chk("tick16_period", tck2, (n % 16 == 0) ? 1'b1 : 1'b0);
      chk("idle_level", lvl1, 1'b0);
    end

    // -------- table-driven vectors --------
    for (int r = 0; r < tbl.size(); r++) begin
      while (n < tbl[r].at) begin
        if (tbl[r].sel) raw2 = tbl[r].raw;
        else            raw1 = tbl[r].raw;
        step();
      end
      if (!tbl[r].sel) begin
        chk("vec_level", lvl1, tbl[r].lvl);
        chk("vec_pulse", pls1, tbl[r].pls);
        chk("vec_req",   req1, tbl[r].req);
        chk("vec_tick",  tck1, tbl[r].tck);
      end else begin
        chk("vec2_level", lvl2, tbl[r].lvl);
        chk("vec2_pulse", pls2, tbl[r].pls);
        chk("vec2_req",   req2, tbl[r].req);
        chk("vec2_tick",  tck2, tbl[r].tck);
      end
    end

    // -------- reset mid-debounce --------
    // dut1 is put into PRESS_WAIT while dut2 is still PRESSED with raw2 high.
    raw1 = 1'b1;
    while (n < 117) step();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_level2", lvl2, 1'b0);
    chk("async_rst_level1", lvl1, 1'b0);
    chk("async_rst_req1",   req1, 1'b0);
    chk("async_rst_tick1",  tck1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #5 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rel_pulse1", pls1, (n == 7) ? 1'b1 : 1'b0);
      chk("rel_pulse2", pls2, (n == 7) ? 1'b1 : 1'b0);
      chk("rel_level1", lvl1, (n >= 7) ? 1'b1 : 1'b0);
      chk("rel_req1",   req1, (n == 7 || n == 8) ? 1'b1 : 1'b0);
      chk("rel_req2",   req2, (n >= 7) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
